// File: rtl/exp7_unidade_controle_pkg.sv
// Shared definitions for the Genius-style game control unit: state codes,
// the control-output bundle and the Moore output decode.
package exp7_unidade_controle_pkg;

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARA        = 4'h1,
    INICIA_RODADA  = 4'h2,
    ESPERA         = 4'h3,
    REGISTRA       = 4'h4,
    COMPARA        = 4'h5,
    PROXIMA_JOGADA = 4'h6,
    PROXIMA_RODADA = 4'h7,
    FIM_ACERTO     = 4'hA,
    FIM_TIMEOUT    = 4'hD,
    FIM_ERRO       = 4'hE
  } estado_t;

  typedef struct packed {
    logic zeraE;
    logic contaE;
    logic zeraL;
    logic contaL;
    logic zeraR;
    logic registraR;
    logic zeraT;
    logic contaT;
    logic pronto;
    logic ganhou;
    logic perdeu;
    logic db_timeout;
  } saidas_t;

  localparam saidas_t SAIDAS_NULAS = saidas_t'(12'h000);

  // Moore decode: the control word asserted while sitting in state e.
  function automatic saidas_t decodifica(input estado_t e);
    saidas_t s;
    s = SAIDAS_NULAS;
    case (e)
      INICIAL: begin
        s = SAIDAS_NULAS;
      end
      PREPARA: begin
        s.zeraE = 1'b1;
        s.zeraL = 1'b1;
        s.zeraR = 1'b1;
        s.zeraT = 1'b1;
      end
      INICIA_RODADA: begin
        s.zeraE = 1'b1;
        s.zeraT = 1'b1;
      end
      ESPERA: begin
        s.contaT = 1'b1;
      end
      REGISTRA: begin
        s.registraR = 1'b1;
      end
      COMPARA: begin
        s = SAIDAS_NULAS;
      end
      PROXIMA_JOGADA: begin
        s.contaE = 1'b1;
        s.zeraT  = 1'b1;
      end
      PROXIMA_RODADA: begin
        s.contaL = 1'b1;
      end
      FIM_ACERTO: begin
        s.pronto = 1'b1;
        s.ganhou = 1'b1;
      end
      FIM_TIMEOUT: begin
        s.pronto     = 1'b1;
        s.perdeu     = 1'b1;
        s.db_timeout = 1'b1;
      end
      FIM_ERRO: begin
        s.pronto = 1'b1;
        s.perdeu = 1'b1;
      end
      default: begin
        s = SAIDAS_NULAS;
      end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/exp7_unidade_controle_if.sv
// Status/control bundle between the game datapath (master) and the
// control unit (slave).
interface exp7_unidade_controle_if;

  logic       iniciar;
  logic       jogada;
  logic       igual;
  logic       fimE;
  logic       fimL;
  logic       timeout;

  logic       zeraE;
  logic       contaE;
  logic       zeraL;
  logic       contaL;
  logic       zeraR;
  logic       registraR;
  logic       zeraT;
  logic       contaT;
  logic       pronto;
  logic       ganhou;
  logic       perdeu;
  logic       db_timeout;
  logic [3:0] db_estado;

  modport slave (
    input  iniciar, jogada, igual, fimE, fimL, timeout,
    output zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraT, contaT,
    output pronto, ganhou, perdeu, db_timeout, db_estado
  );

  modport master (
    output iniciar, jogada, igual, fimE, fimL, timeout,
    input  zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraT, contaT,
    input  pronto, ganhou, perdeu, db_timeout, db_estado
  );

endinterface

// File: rtl/exp7_unidade_controle.sv
// Control unit for the memory game: Moore FSM sequencing rounds, plays,
// comparison and the won / lost-by-error / lost-by-timeout endings.
module exp7_unidade_controle
  import exp7_unidade_controle_pkg::*;
(
  input  logic                          clock,
  input  logic                          reset,
  exp7_unidade_controle_if.slave        uc
);

  estado_t estado_q;
  estado_t estado_d;
  saidas_t saidas_q;
  saidas_t saidas_d;

  // Next-state logic
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL: begin
        if (uc.iniciar) estado_d = PREPARA;
        else            estado_d = INICIAL;
      end
      PREPARA: begin
        estado_d = INICIA_RODADA;
      end
      INICIA_RODADA: begin
        estado_d = ESPERA;
      end
      ESPERA: begin
        // A key press wins over a simultaneous timeout.
        if (uc.jogada)       estado_d = REGISTRA;
        else if (uc.timeout) estado_d = FIM_TIMEOUT;
        else                 estado_d = ESPERA;
      end
      REGISTRA: begin
        estado_d = COMPARA;
      end
      COMPARA: begin
        if (!uc.igual)                estado_d = FIM_ERRO;
        else if (uc.fimE && uc.fimL)  estado_d = FIM_ACERTO;
        else if (uc.fimE)             estado_d = PROXIMA_RODADA;
        else                          estado_d = PROXIMA_JOGADA;
      end
      PROXIMA_JOGADA: begin
        estado_d = ESPERA;
      end
      PROXIMA_RODADA: begin
        estado_d = INICIA_RODADA;
      end
      FIM_ACERTO, FIM_TIMEOUT, FIM_ERRO: begin
        if (uc.iniciar) estado_d = PREPARA;
        else            estado_d = estado_q;
      end
      default: begin
        estado_d = INICIAL;
      end
    endcase
  end

  // Outputs are decoded from the next state so the output flops always
  // mirror the state register, keeping them glitch-free and input-independent.
  always_comb begin
    saidas_d = decodifica(estado_d);
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= INICIAL;
      saidas_q <= SAIDAS_NULAS;
    end else begin
      estado_q <= estado_d;
      saidas_q <= saidas_d;
    end
  end

  assign uc.zeraE      = saidas_q.zeraE;
  assign uc.contaE     = saidas_q.contaE;
  assign uc.zeraL      = saidas_q.zeraL;
  assign uc.contaL     = saidas_q.contaL;
  assign uc.zeraR      = saidas_q.zeraR;
  assign uc.registraR  = saidas_q.registraR;
  assign uc.zeraT      = saidas_q.zeraT;
  assign uc.contaT     = saidas_q.contaT;
  assign uc.pronto     = saidas_q.pronto;
  assign uc.ganhou     = saidas_q.ganhou;
  assign uc.perdeu     = saidas_q.perdeu;
  assign uc.db_timeout = saidas_q.db_timeout;
  assign uc.db_estado  = estado_q;

endmodule

// File: tb/tb_exp7_unidade_controle.sv
// Bench for exp7_unidade_controle: scripted random games with a counter
// datapath model; expected state traces are generated from the game rules.
module tb_exp7_unidade_controle;

  localparam int WIN = 0;
  localparam int ERR = 1;
  localparam int TMO = 2;
  localparam int RST = 3;

  typedef struct {
    bit         ini;
    bit         jog;
    bit         tmo;
    bit         igu;
    logic [3:0] nxt;
  } passo_t;

  logic clock;
  logic reset;
  exp7_unidade_controle_if uc_if();

  exp7_unidade_controle dut (
    .clock (clock),
    .reset (reset),
    .uc    (uc_if)
  );

  int n_checks = 0;
  int n_pass   = 0;
  passo_t roteiro[$];

  logic [4:0] addr;
  logic [4:0] rnd;
  int n_contaL;
  int n_plays;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Datapath stand-in: address/round counters driven by the control outputs.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      addr     <= 5'd0;
      rnd      <= 5'd0;
      n_contaL <= 0;
      n_plays  <= 0;
    end else begin
      if (uc_if.zeraE)       addr <= 5'd0;
      else if (uc_if.contaE) addr <= addr + 5'd1;
      if (uc_if.zeraL)       rnd <= 5'd0;
      else if (uc_if.contaL) rnd <= rnd + 5'd1;
      if (uc_if.zeraL)          n_contaL <= 0;
      else if (uc_if.contaL)    n_contaL <= n_contaL + 1;
      if (uc_if.zeraL)          n_plays <= 0;
      else if (uc_if.registraR) n_plays <= n_plays + 1;
    end
  end

  always_comb begin
    uc_if.fimE = (addr == rnd);
    uc_if.fimL = (rnd == 5'd15);
  end

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_checks++;
    if (obs === esp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, esp, $time);
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  // Expected control word for a state, from the output table of each state.
  function automatic logic [11:0] saidas_esp(input logic [3:0] e);
    logic [11:0] v;
    v[11] = (e == 4'd1) || (e == 4'd2);
    v[10] = (e == 4'd6);
    v[9]  = (e == 4'd1);
    v[8]  = (e == 4'd7);
    v[7]  = (e == 4'd1);
    v[6]  = (e == 4'd4);
    v[5]  = (e == 4'd1) || (e == 4'd2) || (e == 4'd6);
    v[4]  = (e == 4'd3);
    v[3]  = (e >= 4'd10);
    v[2]  = (e == 4'd10);
    v[1]  = (e == 4'd13) || (e == 4'd14);
    v[0]  = (e == 4'd13);
    return v;
  endfunction

  function automatic logic [11:0] saidas_obs();
    return {uc_if.zeraE, uc_if.contaE, uc_if.zeraL, uc_if.contaL, uc_if.zeraR,
            uc_if.registraR, uc_if.zeraT, uc_if.contaT, uc_if.pronto,
            uc_if.ganhou, uc_if.perdeu, uc_if.db_timeout};
  endfunction

  task automatic empilha(input bit ini, input bit jog, input bit tmo, input bit igu,
                         input logic [3:0] nxt);
    passo_t p;
    p.ini = ini; p.jog = jog; p.tmo = tmo; p.igu = igu; p.nxt = nxt;
    roteiro.push_back(p);
  endtask

  // Builds one game: correct plays up to (ur, uj), then the chosen ending.
  task automatic gera_jogo(input int ur, input int uj, input int tipo);
    bit parou;
    logic [3:0] fim;
    logic [3:0] nxt;
    parou = 1'b0;
    fim   = 4'hA;
    empilha(1'b1, rb(), rb(), rb(), 4'h1);
    empilha(rb(), rb(), rb(), rb(), 4'h2);
    for (int k = 0; k <= ur && !parou; k++) begin
      for (int j = 0; j <= k && !parou; j++) begin
        empilha(rb(), rb(), rb(), rb(), 4'h3);
        repeat ($urandom_range(0, 3)) empilha(rb(), 1'b0, 1'b0, rb(), 4'h3);
        if (k == ur && j == uj && tipo != WIN) begin
          parou = 1'b1;
          if (tipo == ERR) begin
            empilha(rb(), 1'b1, rb(), rb(), 4'h4);
            empilha(rb(), rb(), rb(), rb(), 4'h5);
            empilha(rb(), rb(), rb(), 1'b0, 4'hE);
            fim = 4'hE;
          end else if (tipo == TMO) begin
            empilha(rb(), 1'b0, 1'b1, rb(), 4'hD);
            fim = 4'hD;
          end
        end else begin
          // The first play of each round raises timeout alongside jogada.
          empilha(rb(), 1'b1, (j == 0) ? 1'b1 : rb(), rb(), 4'h4);
          empilha(rb(), rb(), rb(), rb(), 4'h5);
          if (j < k)        nxt = 4'h6;
          else if (k == 15) nxt = 4'hA;
          else              nxt = 4'h7;
          empilha(rb(), rb(), rb(), 1'b1, nxt);
          if (nxt == 4'h7) empilha(rb(), rb(), rb(), rb(), 4'h2);
        end
      end
    end
    if (tipo != RST) begin
      repeat ($urandom_range(1, 3)) empilha(1'b0, rb(), rb(), rb(), fim);
    end
  endtask

  task automatic executa();
    passo_t p;
    while (roteiro.size() > 0) begin
      p = roteiro.pop_front();
      uc_if.iniciar = p.ini;
      uc_if.jogada  = p.jog;
      uc_if.timeout = p.tmo;
      uc_if.igual   = p.igu;
      @(posedge clock);
      @(negedge clock);
      verifica("estado", 32'(uc_if.db_estado), 32'(p.nxt));
      verifica("saidas", 32'(saidas_obs()), 32'(saidas_esp(p.nxt)));
    end
  endtask

  initial begin
    int ur;
    reset         = 1'b1;
    uc_if.iniciar = 1'b0;
    uc_if.jogada  = 1'b0;
    uc_if.timeout = 1'b0;
    uc_if.igual   = 1'b0;
    repeat (2) @(negedge clock);
    verifica("reset_estado", 32'(uc_if.db_estado), 32'h0);
    verifica("reset_saidas", 32'(saidas_obs()), 32'h0);
    reset = 1'b0;

    repeat (3) empilha(1'b0, rb(), rb(), rb(), 4'h0);
    executa();

    gera_jogo(15, 15, WIN);
    executa();
    verifica("win_contaL", 32'(n_contaL), 32'd15);
    verifica("win_plays", 32'(n_plays), 32'd136);
    verifica("win_ganhou", 32'(uc_if.ganhou), 32'd1);

    gera_jogo(0, 0, ERR);
    gera_jogo(0, 0, TMO);
    executa();
    for (int g = 0; g < 8; g++) begin
      ur = $urandom_range(0, 4);
      gera_jogo(ur, $urandom_range(0, ur), (g % 2 == 0) ? ERR : TMO);
      executa();
    end

    gera_jogo(3, 1, RST);
    executa();
    #2 reset = 1'b1;
    #1;
    verifica("rst_mid_estado", 32'(uc_if.db_estado), 32'h0);
    verifica("rst_mid_zeraE", 32'(uc_if.zeraE), 32'h0);
    verifica("rst_mid_contaT", 32'(uc_if.contaT), 32'h0);
    verifica("rst_mid_saidas", 32'(saidas_obs()), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) empilha(1'b0, rb(), rb(), rb(), 4'h0);
    executa();

    gera_jogo(1, 1, ERR);
    executa();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/exp7_unidade_controle.md
EXP7_UNIDADE_CONTROLE -- requirements
Module: exp7_unidade_controle

Interface
REQ-001 Parameters: none; all state codes fixed by REQ-024.
REQ-002 clock  in  1  single system clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 iniciar  in  1  start-game request, level-sampled.
REQ-005 jogada  in  1  one-cycle pulse from the datapath when a key press is detected.
REQ-006 igual  in  1  registered play equals memory word at the current address.
REQ-007 fimE  in  1  address counter equals current round number.
REQ-008 fimL  in  1  round counter at its last value (15).
REQ-009 timeout  in  1  play-timeout counter expired.
REQ-010 zeraE, contaE  out  1 each  clear / increment the address counter.
REQ-011 zeraL, contaL  out  1 each  clear / increment the round counter.
REQ-012 zeraR, registraR  out  1 each  clear / load the play register.
REQ-013 zeraT, contaT  out  1 each  clear / enable the timeout counter.
REQ-014 pronto, ganhou, perdeu  out  1 each  game finished / won / lost.
REQ-015 db_timeout  out  1  loss was caused by timeout.
REQ-016 db_estado  out  4  current state code.

Function
REQ-017 Moore FSM: every output decodes only from the state register; no input-to-output combinational path.
REQ-018 INICIAL (0x0): all outputs 0; iniciar=1 -> PREPARA, else stay.
REQ-019 PREPARA (0x1): zeraE, zeraL, zeraR, zeraT = 1; -> INICIA_RODADA unconditionally.
REQ-020 INICIA_RODADA (0x2): zeraE, zeraT = 1; -> ESPERA.
REQ-021 ESPERA (0x3): contaT = 1; jogada -> REGISTRA; else timeout -> FIM_TIMEOUT; else stay. jogada has priority when both are high in the same cycle.
REQ-022 REGISTRA (0x4): registraR = 1; -> COMPARA.
REQ-023 COMPARA (0x5) transitions, in priority order:
  - igual=0 -> FIM_ERRO;
  - fimE=1 and fimL=1 -> FIM_ACERTO;
  - fimE=1 -> PROXIMA_RODADA;
  - otherwise -> PROXIMA_JOGADA.
REQ-024 Remaining states and outputs:
  - PROXIMA_JOGADA (0x6): contaE, zeraT = 1; -> ESPERA.
  - PROXIMA_RODADA (0x7): contaL = 1; -> INICIA_RODADA.
  - FIM_ACERTO (0xA): pronto, ganhou = 1.
  - FIM_TIMEOUT (0xD): pronto, perdeu, db_timeout = 1.
  - FIM_ERRO (0xE): pronto, perdeu = 1.
REQ-025 In any FIM_* state, iniciar=1 -> PREPARA (new game, counters cleared); else hold the state and its outputs.
REQ-026 Round k (0..15) accepts exactly k+1 plays; a full win is 136 plays.
REQ-027 Latency from a jogada pulse to the compare decision is fixed: REGISTRA, then COMPARA, i.e. the decision is taken 2 cycles after the ESPERA edge that saw jogada.
REQ-028 jogada or timeout outside ESPERA is ignored.
REQ-029 Unused codes (0x8, 0x9, 0xB, 0xC, 0xF) -> INICIAL on the next edge.
REQ-030 db_estado always equals the state register.

Reset
REQ-031 reset=1 forces INICIAL immediately, regardless of clock, including mid-round.
REQ-032 While in reset, all outputs are 0 and db_estado = 0x0.
REQ-033 After reset release, the FSM waits for iniciar; no counter-clear pulse is issued until PREPARA.

Structure
REQ-034 The eleven state codes live as named constants in the shared include exp7_estados, reused by the top level and the bench.
REQ-035 Single module; no sub-module. Coding is a next-state block, an asynchronous-reset state register, and an output decode block.

Verification
REQ-036 Reset mid-ESPERA in round 3 -> db_estado=0x0 immediately, with zeraE=contaT=0.
REQ-037 iniciar, one correct play with fimE=1 and fimL=0 -> state sequence 1,2,3,4,5,7,2; contaL high exactly one cycle.
REQ-038 In ESPERA, timeout=1 with no jogada -> 0xD; pronto=perdeu=db_timeout=1, ganhou=0.
REQ-039 In ESPERA, jogada=1 and timeout=1 in the same cycle -> 0x4, not 0xD.
REQ-040 In COMPARA with igual=0 -> 0xE; pronto=perdeu=1, db_timeout=0. Then iniciar=1 -> 0x1 with zeraL=1.
REQ-041 136 correct plays with fimE/fimL modelled from counters -> 0xA with ganhou=1 after the final COMPARA; contaL pulsed 15 times.
